beamscaler_readout_ctrl: RTL and testbench

Readout sequencer and read-port arbiter for the beam scaler RAM. After each completed scaler update it sweeps every populated scaler word in the current read bank, real half then subthreshold half, and streams one framed snapshot out over a valid/ready interface. A single host read port shares the same RAM read port through an arbiter. Every frame is flagged if the bank flips mid-sweep, so downstream never silently mixes two update periods.

---
 rtl/beamscaler_readout_ctrl.sv | 132 +++++++++++++
 tb/tb_beamscaler_readout_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beamscaler_readout_ctrl.sv
// beamscaler_readout_ctrl: sweeps the scaler RAM bank into framed stream snapshots
// and shares the RAM read port with a single host read port.
module beamscaler_readout_ctrl #(
  parameter int NWORDS     = 2,
  parameter int RD_LATENCY = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        enable_i,
  input  logic        done_i,
  input  logic        write_bank_i,
  output logic        scal_rd_o,
  output logic [7:0]  scal_adr_o,
  input  logic [31:0] scal_dat_i,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        m_tuser,
  input  logic        host_rd_i,
  input  logic [7:0]  host_adr_i,
  output logic        host_ack_o,
  output logic [31:0] host_dat_o,
  output logic        host_busy_o,
  output logic [7:0]  overrun_cnt_o,
  output logic [7:0]  err_cnt_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, HEADER, SWEEP_LO, SWEEP_HI, DRAIN} state_t;
  state_t state, state_nx;
  logic bank, err, hp;
  logic [7:0] hadr;
  logic [15:0] frame_cnt;
  logic [6:0] idx;
  logic [2:0] starve;
  logic [RD_LATENCY-1:0] sr_v, sr_h, sr_l;
  logic [33:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, occ;
  logic [AW+1:0] infl;
  logic [33:0] din, head;
  logic credit, sweep_want, host_issue, sweep_issue, idx_end, last_issue;
  logic ret, hdr_push, push, pop, mismatch;
  // Sweep reads still in the return pipe hold a reserved FIFO slot.
  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LATENCY; i++) infl = infl + {{(AW+1){1'b0}}, sr_v[i] & ~sr_h[i]};
  end
  assign occ         = wp - rp;
  assign credit      = ({1'b0, occ} + infl) < (AW+2)'(FIFO_DEPTH);
  assign sweep_want  = (state == SWEEP_LO || state == SWEEP_HI) && credit;
  assign host_issue  = hp && (!sweep_want || starve == 3'd4);
  assign sweep_issue = sweep_want && !host_issue;
  assign idx_end     = idx == 7'(NWORDS - 1);
  assign last_issue  = sweep_issue && state == SWEEP_HI && idx_end;
  assign scal_rd_o   = host_issue || sweep_issue;
  assign scal_adr_o  = host_issue ? hadr : sweep_issue ? {state == SWEEP_HI, idx} : 8'h00;
  assign ret         = sr_v[RD_LATENCY-1] && !sr_h[RD_LATENCY-1];
  assign host_ack_o  = sr_v[RD_LATENCY-1] && sr_h[RD_LATENCY-1];
  assign host_dat_o  = host_ack_o ? scal_dat_i : 32'h0;
  assign host_busy_o = hp;
  assign mismatch    = write_bank_i != bank;
  assign hdr_push    = state == HEADER && credit;
  assign push        = hdr_push || ret;
  // The last sweep word folds in a bank flip seen on its own return cycle.
  assign din = hdr_push ? {2'b00, 8'hB5, 7'b0, bank, frame_cnt}
                        : {sr_l[RD_LATENCY-1], sr_l[RD_LATENCY-1] & (err | mismatch), scal_dat_i};
  assign head     = mem[rp[AW-1:0]];
  assign m_tvalid = occ != '0;
  assign m_tdata  = m_tvalid ? head[31:0] : 32'h0;
  assign m_tuser  = m_tvalid && head[32];
  assign m_tlast  = m_tvalid && head[33];
  assign pop      = m_tvalid && m_tready;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = (done_i && enable_i) ? HEADER : IDLE;
      HEADER:   state_nx = hdr_push ? SWEEP_LO : HEADER;
      SWEEP_LO: state_nx = (sweep_issue && idx_end) ? SWEEP_HI : SWEEP_LO;
      SWEEP_HI: state_nx = last_issue ? DRAIN : SWEEP_HI;
      DRAIN:    state_nx = (infl == '0) ? IDLE : DRAIN;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) if (push) mem[wp[AW-1:0]] <= din;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i)
    if (!wb_rst_n_i) begin
      state         <= IDLE;
      bank          <= 1'b0;
      err           <= 1'b0;
      frame_cnt     <= '0;
      idx           <= '0;
      hp            <= 1'b0;
      hadr          <= '0;
      starve        <= '0;
      sr_v          <= '0;
      sr_h          <= '0;
      sr_l          <= '0;
      wp            <= '0;
      rp            <= '0;
      overrun_cnt_o <= '0;
      err_cnt_o     <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (done_i && enable_i) begin
          bank <= write_bank_i;
          err  <= 1'b0;
        end
      end else err <= err | mismatch;
      if (hdr_push) frame_cnt <= frame_cnt + 16'd1;
      if (sweep_issue) idx <= idx_end ? 7'd0 : idx + 7'd1;
      if (host_issue) hp <= 1'b0;
      else if (host_rd_i && !hp) begin
        hp   <= 1'b1;
        hadr <= host_adr_i;
      end
      starve <= (host_issue || !hp) ? 3'd0 : sweep_issue ? starve + 3'd1 : starve;
      for (int i = 1; i < RD_LATENCY; i++) begin
        sr_v[i] <= sr_v[i-1];
        sr_h[i] <= sr_h[i-1];
        sr_l[i] <= sr_l[i-1];
      end
      sr_v[0] <= scal_rd_o;
      sr_h[0] <= host_issue;
      sr_l[0] <= last_issue;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (done_i && state != IDLE && overrun_cnt_o != 8'hFF) overrun_cnt_o <= overrun_cnt_o + 8'd1;
      if (pop && m_tlast && m_tuser && err_cnt_o != 8'hFF) err_cnt_o <= err_cnt_o + 8'd1;
    end
endmodule

// File: tb/tb_beamscaler_readout_ctrl.sv
// tb_beamscaler_readout_ctrl: randomized scoreboard bench with a RAM model and a
// frame-level reference model of the readout stream, host port and counters.
module tb_beamscaler_readout_ctrl;
  localparam int NW = 2, LAT = 2, FD = 4, WNW = 8;
  logic wb_clk_i = 1'b0, wb_rst_n_i = 1'b0, enable_i = 1'b0, done_i = 1'b0;
  logic write_bank_i = 1'b0, m_tready = 1'b0, host_rd_i = 1'b0;
  logic [7:0] host_adr_i = 8'h0;
  logic scal_rd_o, m_tvalid, m_tlast, m_tuser, host_ack_o, host_busy_o;
  logic [7:0] scal_adr_o, overrun_cnt_o, err_cnt_o;
  logic [31:0] scal_dat_i, m_tdata, host_dat_o;
  logic w_rd, w_tvalid, w_tlast, w_tuser, w_ack, w_busy;
  logic [7:0] w_adr, w_ovr, w_err;
  logic [31:0] w_rdat, w_tdata, w_dat;
  logic [31:0] mem [256];
  logic p_v [LAT], q_v [LAT];
  logic [7:0] p_a [LAT], q_a [LAT];
  typedef struct {logic [31:0] d; int cyc;} hexp_t;
  logic [33:0] sq [$];
  hexp_t hq [$];
  int checks = 0, failures = 0, cyc = 0, pct = 100, rd_cnt = 0, run = 0, w_seen = 0;
  int fc = 0, ovr = 0, errc = 0;
  bit stress = 0, held = 0;
  logic [7:0] stress_adr = 8'h40;
  logic [33:0] prev, e;
  hexp_t h;

  beamscaler_readout_ctrl #(.NWORDS(NW), .RD_LATENCY(LAT), .FIFO_DEPTH(FD)) dut (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .enable_i(enable_i), .done_i(done_i),
    .write_bank_i(write_bank_i), .scal_rd_o(scal_rd_o), .scal_adr_o(scal_adr_o),
    .scal_dat_i(scal_dat_i), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .m_tlast(m_tlast), .m_tuser(m_tuser), .host_rd_i(host_rd_i), .host_adr_i(host_adr_i),
    .host_ack_o(host_ack_o), .host_dat_o(host_dat_o), .host_busy_o(host_busy_o),
    .overrun_cnt_o(overrun_cnt_o), .err_cnt_o(err_cnt_o));

  // Wider instance: long enough sweeps to exercise host anti-starvation.
  beamscaler_readout_ctrl #(.NWORDS(WNW), .RD_LATENCY(LAT), .FIFO_DEPTH(FD)) u_wide (
    .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i), .enable_i(enable_i), .done_i(done_i),
    .write_bank_i(write_bank_i), .scal_rd_o(w_rd), .scal_adr_o(w_adr),
    .scal_dat_i(w_rdat), .m_tdata(w_tdata), .m_tvalid(w_tvalid), .m_tready(1'b1),
    .m_tlast(w_tlast), .m_tuser(w_tuser), .host_rd_i(host_rd_i), .host_adr_i(host_adr_i),
    .host_ack_o(w_ack), .host_dat_o(w_dat), .host_busy_o(w_busy),
    .overrun_cnt_o(w_ovr), .err_cnt_o(w_err));

  always #5 wb_clk_i = ~wb_clk_i;
  always @(posedge wb_clk_i) cyc <= cyc + 1;

  always @(posedge wb_clk_i) begin
    p_v[0] <= scal_rd_o;
    p_a[0] <= scal_adr_o;
    q_v[0] <= w_rd;
    q_a[0] <= w_adr;
    for (int i = 1; i < LAT; i++) begin
      p_v[i] <= p_v[i-1];
      p_a[i] <= p_a[i-1];
      q_v[i] <= q_v[i-1];
      q_a[i] <= q_a[i-1];
    end
  end
  assign scal_dat_i = p_v[LAT-1] ? mem[p_a[LAT-1]] : 32'h0;
  assign w_rdat     = q_v[LAT-1] ? mem[q_a[LAT-1]] : 32'h0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge wb_clk_i);
    #1;
  endtask

  // Expected frame: header, real half, subthreshold half; flag only on the last word.
  task automatic start_frame(input bit user);
    logic [7:0] a;
    sq.push_back({2'b00, 8'hB5, 7'b0, write_bank_i, 16'(fc)});
    for (int hh = 0; hh < 2; hh++)
      for (int i = 0; i < NW; i++) begin
        a = hh == 1 ? 8'(128 + i) : 8'(i);
        sq.push_back({hh == 1 && i == NW - 1, hh == 1 && i == NW - 1 && user, mem[a]});
      end
    fc = (fc + 1) % 65536;
    if (user && errc < 255) errc++;
  endtask

  task automatic pulse_done(input bit user);
    start_frame(user);
    done_i = 1'b1;
    tick;
    done_i = 1'b0;
  endtask

  task automatic pulse_overrun;
    done_i = 1'b1;
    tick;
    done_i = 1'b0;
    if (ovr < 255) ovr++;
    tick;
  endtask

  task automatic wait_frame;
    int n = 0;
    while (sq.size() != 0 && n < 3000) begin
      tick;
      n++;
    end
    chk("frame_beats_left", 64'(sq.size()), 64'd0);
    sq.delete();
    repeat (4) tick;
  endtask

  task automatic outs_zero(input string name);
    chk({name, "_stream"}, 64'({m_tvalid, m_tlast, m_tuser, m_tdata}), 64'd0);
    chk({name, "_misc"}, 64'({scal_rd_o, scal_adr_o, host_ack_o, host_busy_o, overrun_cnt_o, err_cnt_o}), 64'd0);
    chk({name, "_hdat"}, 64'(host_dat_o), 64'd0);
  endtask

  initial forever begin
    @(posedge wb_clk_i);
    #1;
    m_tready = $urandom_range(0, 99) < pct;
  end

  // Monitor: stream scoreboard, host acks, read accounting and starvation runs.
  initial forever begin
    @(negedge wb_clk_i);
    if (wb_rst_n_i) begin
      if (held) chk("hold_stable", 64'({m_tvalid, m_tlast, m_tuser, m_tdata}), 64'({1'b1, prev}));
      if (m_tvalid && m_tready) begin
        if (sq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_beat: got %h, expected no beat", {m_tlast, m_tuser, m_tdata});
        end else begin
          e = sq.pop_front();
          chk("beat", 64'({m_tlast, m_tuser, m_tdata}), 64'(e));
        end
      end
      held = m_tvalid && !m_tready;
      prev = {m_tlast, m_tuser, m_tdata};
      if (host_ack_o) begin
        if (stress) chk("host_stress_dat", 64'(host_dat_o), 64'(mem[stress_adr]));
        else if (hq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL stray_ack: got %h, expected no ack", host_dat_o);
        end else begin
          h = hq.pop_front();
          chk("host_dat", 64'(host_dat_o), 64'(h.d));
          chk("host_ack_cycle", 64'(cyc), 64'(h.cyc));
        end
      end
      if (scal_rd_o) rd_cnt++;
      if (stress && w_ack) chk("wide_host_dat", 64'(w_dat), 64'(mem[stress_adr]));
      if (stress && w_rd) begin
        if (w_adr == stress_adr) begin
          w_seen++;
          run = -1;
        end else begin
          run++;
          chk("starve_run_over4", 64'(run > 4), 64'd0);
        end
      end
    end else held = 0;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int r0;
    for (int a = 0; a < 256; a++) mem[a] = {4'h0, 12'($urandom), 4'h0, 8'(a), 4'($urandom)};
    repeat (2) tick;
    @(negedge wb_clk_i);
    outs_zero("reset");
    tick;
    wb_rst_n_i = 1'b1;
    enable_i = 1'b1;
    repeat (2) tick;
    // Basic frame and header/first-read latency.
    write_bank_i = 1'b1;
    pulse_done(0);
    @(negedge wb_clk_i);
    chk("hdr_not_early", 64'(m_tvalid), 64'd0);
    tick;
    @(negedge wb_clk_i);
    chk("hdr_latency", 64'(m_tvalid), 64'd1);
    chk("first_read", 64'({scal_rd_o, scal_adr_o}), 64'h100);
    wait_frame;
    chk("err_cnt_clean", 64'(err_cnt_o), 64'(errc));
    // Random backpressure at ~30% ready.
    pct = 30;
    repeat (6) begin
      write_bank_i = 1'($urandom);
      repeat ($urandom_range(0, 5)) tick;
      pulse_done(0);
      wait_frame;
    end
    pct = 100;
    // done without enable: no frame, no overrun.
    enable_i = 1'b0;
    done_i = 1'b1;
    tick;
    done_i = 1'b0;
    repeat (20) tick;
    chk("disabled_overrun", 64'(overrun_cnt_o), 64'(ovr));
    enable_i = 1'b1;
    // Bank flips during the upper-half sweep.
    write_bank_i = 1'b0;
    pulse_done(1);
    repeat (3) tick;
    write_bank_i = 1'b1;
    wait_frame;
    chk("err_cnt_flip", 64'(err_cnt_o), 64'(errc));
    pulse_done(0);
    wait_frame;
    chk("err_cnt_after_clean", 64'(err_cnt_o), 64'(errc));
    // Overruns during an active frame.
    pulse_done(0);
    tick;
    pulse_overrun;
    pulse_overrun;
    wait_frame;
    chk("overrun_2", 64'(overrun_cnt_o), 64'(ovr));
    // Stalled stream: credit limits reads, then overrun saturation.
    pct = 0;
    tick;
    pulse_done(0);
    r0 = rd_cnt;
    repeat (20) tick;
    chk("credit_reads", 64'(rd_cnt - r0), 64'(FD - 1));
    r0 = rd_cnt;
    repeat (300) pulse_overrun;
    chk("credit_stall", 64'(rd_cnt - r0), 64'd0);
    pct = 100;
    wait_frame;
    chk("overrun_sat", 64'(overrun_cnt_o), 64'(ovr));
    repeat (30) tick;
    // Isolated host read, then a repeat while pending is dropped.
    host_adr_i = 8'h23;
    host_rd_i = 1'b1;
    hq.push_back('{mem[8'h23], cyc + 1 + LAT});
    tick;
    host_adr_i = 8'h91;
    tick;
    host_rd_i = 1'b0;
    repeat (8) tick;
    // Host request together with done in IDLE.
    host_adr_i = 8'h57;
    host_rd_i = 1'b1;
    hq.push_back('{mem[8'h57], cyc + 1 + LAT});
    pulse_done(0);
    host_rd_i = 1'b0;
    wait_frame;
    chk("host_queue_empty", 64'(hq.size()), 64'd0);
    repeat (30) tick;
    // Host requests every cycle across a sweep.
    pct = 30;
    stress = 1;
    run = -1;
    host_adr_i = stress_adr;
    host_rd_i = 1'b1;
    pulse_done(0);
    wait_frame;
    pct = 100;
    repeat (40) tick;
    host_rd_i = 1'b0;
    repeat (8) tick;
    stress = 0;
    chk("host_served", 64'(w_seen >= 3), 64'd1);
    repeat (10) tick;
    // Reset in the middle of the lower sweep.
    pulse_done(0);
    tick;
    wb_rst_n_i = 1'b0;
    sq.delete();
    hq.delete();
    fc = 0;
    ovr = 0;
    errc = 0;
    @(negedge wb_clk_i);
    outs_zero("mid_reset");
    tick;
    wb_rst_n_i = 1'b1;
    repeat (20) tick;
    pulse_done(0);
    wait_frame;
    chk("post_reset_overrun", 64'(overrun_cnt_o), 64'(ovr));
    chk("post_reset_err", 64'(err_cnt_o), 64'(errc));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
